// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier issue/return controller.
// mult_op_t describes an operand pair at the default widths.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } mult_state_e;

    localparam int MULT_DATA_WIDTH = 32;
    localparam int MULT_TAG_WIDTH  = 4;

    // Watchdog budget: the longest multiplier latency plus some margin.
    function automatic int default_timeout(input int data_width);
        return 2 * data_width + 16;
    endfunction

    localparam int MULT_TIMEOUT = default_timeout(MULT_DATA_WIDTH);

    typedef struct packed {
        logic [MULT_DATA_WIDTH-1:0] a;
        logic [MULT_DATA_WIDTH-1:0] b;
        logic [MULT_TAG_WIDTH-1:0]  tag;
    } mult_op_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Synchronous FIFO for tagged operand pairs. It uses extra-bit pointers,
// so full and empty are told apart without a separate counter.
module mult_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/return controller for mult_booth. It buffers tagged operand pairs,
// keeps one multiplication in flight, and returns each result with its tag.
module mult_issue_ctrl
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH = MULT_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = MULT_TAG_WIDTH,
    parameter int TIMEOUT    = default_timeout(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_a,
    input  logic [DATA_WIDTH-1:0]   s_b,
    input  logic [TAG_WIDTH-1:0]    s_tag,
    output logic                    m_valid,
    output logic [DATA_WIDTH-1:0]   m_a,
    output logic [DATA_WIDTH-1:0]   m_b,
    input  logic                    mult_done,
    input  logic [2*DATA_WIDTH-1:0] mult_c,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [2*DATA_WIDTH-1:0] r_c,
    output logic [TAG_WIDTH-1:0]    r_tag,
    output logic                    r_err,
    output logic                    err_sticky
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [TAG_WIDTH-1:0]  tag;
    } op_t;

    localparam int WD_W = $clog2(TIMEOUT + 1);

    mult_state_e          state;
    mult_state_e          state_nxt;
    op_t                  push_op;
    op_t                  head_op;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [TAG_WIDTH-1:0] issue_tag;
    logic [WD_W-1:0]      wd_cnt;
    logic                 issue;
    logic                 done_ok;
    logic                 timeout;
    logic                 spurious;
    logic                 release_res;

    assign push_op = '{a: s_a, b: s_b, tag: s_tag};
    assign s_ready = !fifo_full;

    mult_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(op_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s_valid),
        .push_data (push_op),
        .pop       (issue),
        .pop_data  (head_op),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A mult_done that arrives in IDLE is dropped without a flag. It may
    // belong to an operation that was in flight across a reset.
    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        done_ok     = 1'b0;
        timeout     = 1'b0;
        spurious    = 1'b0;
        release_res = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mult_done) begin
                    done_ok   = 1'b1;
                    state_nxt = HOLD;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                spurious = mult_done;
                if (r_ready) begin
                    release_res = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_a       <= '0;
            m_b       <= '0;
            issue_tag <= '0;
        end else begin
            m_valid <= issue;
            if (issue) begin
                m_a       <= head_op.a;
                m_b       <= head_op.b;
                issue_tag <= head_op.tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (issue) begin
            wd_cnt <= '0;
        end else if (state == WAIT && wd_cnt != WD_W'(TIMEOUT)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // The result stays frozen in HOLD. A late done cannot overwrite it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_c        <= '0;
            r_tag      <= '0;
            r_err      <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            if (done_ok) begin
                r_valid <= 1'b1;
                r_c     <= mult_c;
                r_tag   <= issue_tag;
                r_err   <= 1'b0;
            end else if (timeout) begin
                r_valid <= 1'b1;
                r_c     <= '0;
                r_tag   <= issue_tag;
                r_err   <= 1'b1;
            end else if (release_res) begin
                r_valid <= 1'b0;
            end
            if (timeout || spurious) err_sticky <= 1'b1;
        end
    end

endmodule
